// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Round-robin arbiter that merges NREQ writeback requesters onto a single
// registered regfile write port.
//   * req_ready is combinational and one-hot (or zero).
//   * The winning request is captured into a one-deep output stage and
//     presented on rf_we/rf_waddr/rf_wdata/grant_id the following cycle.
//   * Writes to address 0 (hard-wired zero register) are accepted but never
//     raise rf_we.
//   * flush kills this cycle's grant and empties the output stage.
// Optional feature (compile-time macro RF_WB_CONFLICT_EN):
//   adds a registered 'conflict' output that pulses when two or more valid
//   requesters target the same nonzero address in the same cycle.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    parameter  int NREQ  = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
    output logic [IW-1:0]         grant_id,
    output logic [IW-1:0]         rr_ptr
`ifdef RF_WB_CONFLICT_EN
    ,
    output logic                  conflict
`endif
);

    // Wrap (base + offset) into the range 0..NREQ-1. offset is always
    // below NREQ, so one conditional subtraction is enough.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base,
                                               input int unsigned   offset);
        int unsigned sum;
        sum = {{(32-IW){1'b0}}, base} + offset;
        if (sum >= int'(NREQ)) begin
            sum = sum - int'(NREQ);
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    // Arbitration results (combinational)
    logic [NREQ-1:0]  ready_s;
    logic             xfer_s;
    logic [IW-1:0]    grant_idx_s;
    logic [IW-1:0]    cand_idx_s;
    logic [AW-1:0]    sel_addr_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             addr_nz_s;

    // Output stage and pointer state
    logic             rf_we_r;
    logic [AW-1:0]    rf_waddr_r;
    logic [WIDTH-1:0] rf_wdata_r;
    logic [IW-1:0]    grant_id_r;
    logic [IW-1:0]    rr_ptr_r;

    // Round-robin search from rr_ptr; reset and flush suppress any grant.
    always_comb begin
        ready_s     = '0;
        xfer_s      = 1'b0;
        grant_idx_s = '0;
        cand_idx_s  = '0;
        if (!rst_n || flush) begin
            xfer_s      = 1'b0;
            grant_idx_s = '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand_idx_s = rr_index(rr_ptr_r, k);
                if (!xfer_s && req_valid[cand_idx_s]) begin
                    xfer_s      = 1'b1;
                    grant_idx_s = cand_idx_s;
                end else begin
                    xfer_s      = xfer_s;
                    grant_idx_s = grant_idx_s;
                end
            end
        end
        if (xfer_s) begin
            ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            ready_s = '0;
        end
    end

    // Pick the granted requester's address and data from the flat buses.
    always_comb begin
        sel_addr_s = req_addr[grant_idx_s*AW +: AW];
        sel_data_s = req_data[grant_idx_s*WIDTH +: WIDTH];
        addr_nz_s  = |sel_addr_s;
    end

    // Output stage: load on transfer (x0 writes load but stay disabled),
    // otherwise drop the enable and hold the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
        end else if (xfer_s) begin
            rf_we_r    <= addr_nz_s;
            rf_waddr_r <= sel_addr_s;
            rf_wdata_r <= sel_data_s;
            grant_id_r <= grant_idx_s;
            rr_ptr_r   <= rr_index(grant_idx_s, 1);
        end else begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= rf_waddr_r;
            rf_wdata_r <= rf_wdata_r;
            grant_id_r <= grant_id_r;
            rr_ptr_r   <= rr_ptr_r;
        end
    end

    assign req_ready = ready_s;
    assign rf_we     = rf_we_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign grant_id  = grant_id_r;
    assign rr_ptr    = rr_ptr_r;

`ifdef RF_WB_CONFLICT_EN
    logic conflict_s;
    logic conflict_r;

    // Detect any pair of valid requesters aiming at the same nonzero address;
    // purely observational, it never feeds the arbitration.
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (req_valid[i] && req_valid[j] &&
                    (req_addr[i*AW +: AW] == req_addr[j*AW +: AW]) &&
                    (|req_addr[i*AW +: AW])) begin
                    conflict_s = 1'b1;
                end else begin
                    conflict_s = conflict_s;
                end
            end
        end
    end

    // Register the conflict flag as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_r <= 1'b0;
        end else begin
            conflict_r <= conflict_s;
        end
    end

    assign conflict = conflict_r;
`endif

endmodule
